// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Holds PCF and selects the next PC from exception entry, stall, eret return
// and the decode-stage redirect. Drives the F/D register with instruction,
// PC+4, fetch exception code (AdEL) and the delay-slot flag.
// Optional feature: define FETCH_RANGE_CHK_EN to also flag fetches outside
// the 0x0000_3000..0x0000_6FFC instruction window as AdEL.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallF,
   input  logic [1:0]  PCSrcD,
   input  logic [31:0] ext_immD,
   input  logic [31:0] ext_indexD,
   input  logic [31:0] GPR_rsD,
   input  logic        jumpD,
   input  logic        eretD,
   input  logic [31:0] EPC,
   input  logic        exc_req,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] InstrD,
   output logic [31:0] PC_4D,
   output logic [4:0]  ExcCodeD,
   output logic        if_bdD
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   // Fetch address error: misaligned PC, plus out-of-window PC when enabled.
   function automatic logic fetch_adel(input logic [31:0] pc);
      logic bad;
      bad = (pc[1:0] != 2'b00);
`ifdef FETCH_RANGE_CHK_EN
      if ((pc < 32'h0000_3000) || (pc > 32'h0000_6FFC)) begin
         bad = 1'b1;
      end else begin
         bad = bad;
      end
`endif
      return bad;
   endfunction

   logic [31:0] pcf_q, pcf_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic [4:0]  exc_q, exc_d;
   logic        bd_q, bd_d;

   logic [31:0] pc_4f_s;
   logic [31:0] branch_tgt_s;
   logic [31:0] redirect_s;
   logic        adel_s;

   // Next PC and F/D contents, priority: exception, stall, eret, normal fetch.
   always_comb begin
      pc_4f_s      = pcf_q + 32'd4;
      branch_tgt_s = pc4_q + {ext_immD[29:0], 2'b00};
      adel_s       = fetch_adel(pcf_q);

      case (PCSrcD)
         2'b00:   redirect_s = pc_4f_s;
         2'b01:   redirect_s = branch_tgt_s;
         2'b10:   redirect_s = ext_indexD;
         2'b11:   redirect_s = GPR_rsD;
         default: redirect_s = pc_4f_s;
      endcase

      pcf_d   = pcf_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      exc_d   = exc_q;
      bd_d    = bd_q;

      if (exc_req) begin
         // Exception beats stall and eret; the fetched instruction is discarded.
         pcf_d   = EXC_ENTRY;
         instr_d = 32'h0000_0000;
         pc4_d   = 32'h0000_0000;
         exc_d   = EXC_NONE;
         bd_d    = 1'b0;
      end else if (stallF) begin
         // Hold everything; decode keeps re-presenting any pending redirect.
         pcf_d   = pcf_q;
      end else if (eretD) begin
         // eret has no delay slot, so the instruction behind it is squashed.
         pcf_d   = EPC;
         instr_d = 32'h0000_0000;
         pc4_d   = 32'h0000_0000;
         exc_d   = EXC_NONE;
         bd_d    = 1'b0;
      end else begin
         pcf_d   = redirect_s;
         instr_d = adel_s ? 32'h0000_0000 : imem_rdata;
         pc4_d   = pc_4f_s;
         exc_d   = adel_s ? EXC_ADEL : EXC_NONE;
         bd_d    = jumpD;
      end
   end

   // PC and F/D pipeline register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcf_q   <= RESET_PC;
         instr_q <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0000;
         exc_q   <= EXC_NONE;
         bd_q    <= 1'b0;
      end else begin
         pcf_q   <= pcf_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         exc_q   <= exc_d;
         bd_q    <= bd_d;
      end
   end

   assign imem_addr = pcf_q;
   assign InstrD    = instr_q;
   assign PC_4D     = pc4_q;
   assign ExcCodeD  = exc_q;
   assign if_bdD    = bd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run of fetch_stage,
// checked against a behavioural pipeline model kept in the bench.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallF;
   logic [1:0]  PCSrcD;
   logic [31:0] ext_immD, ext_indexD, GPR_rsD, EPC;
   logic        jumpD, eretD, exc_req;
   logic [31:0] imem_rdata, imem_addr, InstrD, PC_4D;
   logic [4:0]  ExcCodeD;
   logic        if_bdD;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic [4:0]  m_exc;
   logic        m_bd;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC), .EXC_ENTRY(EXC_ENTRY)) dut (
      .clk(clk), .reset(reset), .stallF(stallF), .PCSrcD(PCSrcD),
      .ext_immD(ext_immD), .ext_indexD(ext_indexD), .GPR_rsD(GPR_rsD),
      .jumpD(jumpD), .eretD(eretD), .EPC(EPC), .exc_req(exc_req),
      .imem_rdata(imem_rdata), .imem_addr(imem_addr), .InstrD(InstrD),
      .PC_4D(PC_4D), .ExcCodeD(ExcCodeD), .if_bdD(if_bdD)
   );

   // Instruction memory contents: a fixed word at the reset PC, a hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h2408_0001;
      return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
   endfunction

   always_comb imem_rdata = mem_word(imem_addr);

   function automatic logic model_adel(input logic [31:0] pc);
      logic bad;
      bad = (pc % 32'd4) != 32'd0;
`ifdef FETCH_RANGE_CHK_EN
      if (pc < 32'h0000_3000 || pc > 32'h0000_6FFC) bad = 1'b1;
`endif
      return bad;
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_instr = 32'd0; m_pc4 = 32'd0; m_exc = 5'd0; m_bd = 1'b0;
   endtask

   // Apply the pipeline rules for one clock edge using the current inputs.
   task automatic model_edge();
      logic [31:0] nxt;
      if (exc_req) begin
         m_pc = EXC_ENTRY; m_instr = 32'd0; m_pc4 = 32'd0; m_exc = 5'd0; m_bd = 1'b0;
      end else if (stallF) begin
         m_pc = m_pc;
      end else if (eretD) begin
         m_pc = EPC; m_instr = 32'd0; m_pc4 = 32'd0; m_exc = 5'd0; m_bd = 1'b0;
      end else begin
         if (PCSrcD == 2'd1)      nxt = m_pc4 + ext_immD * 32'd4;
         else if (PCSrcD == 2'd2) nxt = ext_indexD;
         else if (PCSrcD == 2'd3) nxt = GPR_rsD;
         else                     nxt = m_pc + 32'd4;
         m_instr = model_adel(m_pc) ? 32'd0 : mem_word(m_pc);
         m_exc   = model_adel(m_pc) ? 5'd4 : 5'd0;
         m_pc4   = m_pc + 32'd4;
         m_bd    = jumpD;
         m_pc    = nxt;
      end
   endtask

   task automatic idle_inputs();
      stallF = 1'b0; PCSrcD = 2'b00; ext_immD = 32'd0; ext_indexD = 32'd0;
      GPR_rsD = 32'd0; jumpD = 1'b0; eretD = 1'b0; EPC = 32'd0; exc_req = 1'b0;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      #12;
      model_reset();
      n_checks += 5;
      if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", imem_addr, RESET_PC); end
      if (InstrD !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", InstrD); end
      if (PC_4D !== 32'd0) begin n_fail++; $display("FAIL reset_pc4 got %h exp 0", PC_4D); end
      if (ExcCodeD !== 5'd0) begin n_fail++; $display("FAIL reset_exc got %0d exp 0", ExcCodeD); end
      if (if_bdD !== 1'b0) begin n_fail++; $display("FAIL reset_bd got %b exp 0", if_bdD); end
      @(posedge clk); #1;
      reset = 1'b1;
      tick();
      n_checks += 5;
      if (InstrD !== 32'h2408_0001) begin n_fail++; $display("FAIL first_instr got %h exp 24080001", InstrD); end
      if (PC_4D !== 32'h0000_3004) begin n_fail++; $display("FAIL first_pc4 got %h exp 3004", PC_4D); end
      if (ExcCodeD !== 5'd0) begin n_fail++; $display("FAIL first_exc got %0d exp 0", ExcCodeD); end
      if (if_bdD !== 1'b0) begin n_fail++; $display("FAIL first_bd got %b exp 0", if_bdD); end
      if (imem_addr !== 32'h0000_3004) begin n_fail++; $display("FAIL first_pcf got %h exp 3004", imem_addr); end
   endtask

   task automatic test_branch();
      // beq at 0x3000 in D, offset 3 words: target 0x3004 + 12 = 0x3010
      PCSrcD = 2'b01; ext_immD = 32'd3; jumpD = 1'b1;
      tick();
      idle_inputs();
      n_checks += 4;
      if (InstrD !== mem_word(32'h0000_3004)) begin n_fail++; $display("FAIL beq_slot_instr got %h exp %h", InstrD, mem_word(32'h0000_3004)); end
      if (PC_4D !== 32'h0000_3008) begin n_fail++; $display("FAIL beq_slot_pc4 got %h exp 3008", PC_4D); end
      if (if_bdD !== 1'b1) begin n_fail++; $display("FAIL beq_slot_bd got %b exp 1", if_bdD); end
      if (imem_addr !== 32'h0000_3010) begin n_fail++; $display("FAIL beq_target got %h exp 3010", imem_addr); end
   endtask

   task automatic test_jr_misaligned();
      PCSrcD = 2'b11; GPR_rsD = 32'h0000_3002; jumpD = 1'b1;
      tick();
      idle_inputs();
      n_checks += 3;
      if (ExcCodeD !== 5'd0) begin n_fail++; $display("FAIL jr_slot_exc got %0d exp 0", ExcCodeD); end
      if (InstrD !== mem_word(32'h0000_3010)) begin n_fail++; $display("FAIL jr_slot_instr got %h exp %h", InstrD, mem_word(32'h0000_3010)); end
      if (imem_addr !== 32'h0000_3002) begin n_fail++; $display("FAIL jr_target got %h exp 3002", imem_addr); end
      tick();
      n_checks += 4;
      if (InstrD !== 32'd0) begin n_fail++; $display("FAIL adel_instr got %h exp 0", InstrD); end
      if (ExcCodeD !== 5'd4) begin n_fail++; $display("FAIL adel_exc got %0d exp 4", ExcCodeD); end
      if (PC_4D !== 32'h0000_3006) begin n_fail++; $display("FAIL adel_pc4 got %h exp 3006", PC_4D); end
      if (if_bdD !== 1'b0) begin n_fail++; $display("FAIL adel_bd got %b exp 0", if_bdD); end
      PCSrcD = 2'b10; ext_indexD = 32'h0000_3100;
      tick();
      idle_inputs();
   endtask

   task automatic test_stall_redirect();
      logic [31:0] pc_s, ins_s, pc4_s;
      pc_s = imem_addr; ins_s = InstrD; pc4_s = PC_4D;
      stallF = 1'b1; PCSrcD = 2'b10; ext_indexD = 32'h0000_3400; jumpD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks += 3;
         if (imem_addr !== pc_s) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp %h", i, imem_addr, pc_s); end
         if (InstrD !== ins_s) begin n_fail++; $display("FAIL stall_instr[%0d] got %h exp %h", i, InstrD, ins_s); end
         if (PC_4D !== pc4_s) begin n_fail++; $display("FAIL stall_pc4[%0d] got %h exp %h", i, PC_4D, pc4_s); end
      end
      stallF = 1'b0;
      tick();
      idle_inputs();
      n_checks += 2;
      if (imem_addr !== 32'h0000_3400) begin n_fail++; $display("FAIL unstall_target got %h exp 3400", imem_addr); end
      if (if_bdD !== 1'b1) begin n_fail++; $display("FAIL unstall_bd got %b exp 1", if_bdD); end
   endtask

   task automatic test_exc_eret();
      stallF = 1'b1; eretD = 1'b1; EPC = 32'h0000_3020; exc_req = 1'b1;
      tick();
      idle_inputs();
      n_checks += 5;
      if (imem_addr !== EXC_ENTRY) begin n_fail++; $display("FAIL exc_pc got %h exp %h", imem_addr, EXC_ENTRY); end
      if (InstrD !== 32'd0) begin n_fail++; $display("FAIL exc_instr got %h exp 0", InstrD); end
      if (PC_4D !== 32'd0) begin n_fail++; $display("FAIL exc_pc4 got %h exp 0", PC_4D); end
      if (ExcCodeD !== 5'd0) begin n_fail++; $display("FAIL exc_code got %0d exp 0", ExcCodeD); end
      if (if_bdD !== 1'b0) begin n_fail++; $display("FAIL exc_bd got %b exp 0", if_bdD); end
      tick();
      n_checks += 1;
      if (InstrD !== mem_word(EXC_ENTRY)) begin n_fail++; $display("FAIL handler_instr got %h exp %h", InstrD, mem_word(EXC_ENTRY)); end
      eretD = 1'b1; EPC = 32'h0000_3020;
      tick();
      idle_inputs();
      n_checks += 3;
      if (imem_addr !== 32'h0000_3020) begin n_fail++; $display("FAIL eret_pc got %h exp 3020", imem_addr); end
      if (InstrD !== 32'd0) begin n_fail++; $display("FAIL eret_instr got %h exp 0", InstrD); end
      if (PC_4D !== 32'd0) begin n_fail++; $display("FAIL eret_pc4 got %h exp 0", PC_4D); end
   endtask

   task automatic test_range();
      PCSrcD = 2'b10; ext_indexD = 32'h0000_7000;
      tick();
      idle_inputs();
      tick();
      n_checks += 2;
`ifdef FETCH_RANGE_CHK_EN
      if (ExcCodeD !== 5'd4) begin n_fail++; $display("FAIL range_exc got %0d exp 4", ExcCodeD); end
      if (InstrD !== 32'd0) begin n_fail++; $display("FAIL range_instr got %h exp 0", InstrD); end
`else
      if (ExcCodeD !== 5'd0) begin n_fail++; $display("FAIL range_exc got %0d exp 0", ExcCodeD); end
      if (InstrD !== mem_word(32'h0000_7000)) begin n_fail++; $display("FAIL range_instr got %h exp %h", InstrD, mem_word(32'h0000_7000)); end
`endif
      PCSrcD = 2'b10; ext_indexD = 32'h0000_3000;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid_stall();
      stallF = 1'b1; PCSrcD = 2'b10; ext_indexD = 32'h0000_3800;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_checks += 3;
      if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL midreset_pc got %h exp %h", imem_addr, RESET_PC); end
      if (InstrD !== 32'd0) begin n_fail++; $display("FAIL midreset_instr got %h exp 0", InstrD); end
      if (PC_4D !== 32'd0) begin n_fail++; $display("FAIL midreset_pc4 got %h exp 0", PC_4D); end
      idle_inputs();
      @(posedge clk); #1;
      reset = 1'b1;
      tick();
      n_checks += 2;
      if (imem_addr !== 32'h0000_3004) begin n_fail++; $display("FAIL postreset_pc got %h exp 3004", imem_addr); end
      if (InstrD !== 32'h2408_0001) begin n_fail++; $display("FAIL postreset_instr got %h exp 24080001", InstrD); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         stallF  = ($urandom_range(0, 3) == 0);
         exc_req = ($urandom_range(0, 19) == 0);
         eretD   = ($urandom_range(0, 15) == 0);
         jumpD   = $urandom_range(0, 1);
         PCSrcD  = $urandom_range(0, 3);
         ext_immD   = $urandom_range(0, 64) - 32;
         ext_indexD = 32'h0000_2F00 + $urandom_range(0, 32'h4200) * 4;
         GPR_rsD    = 32'h0000_2F00 + $urandom_range(0, 32'h10800);
         EPC        = 32'h0000_3000 + $urandom_range(0, 32'h0FFF) * 4;
         tick();
         n_checks += 5;
         if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, imem_addr, m_pc); end
         if (InstrD !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d] got %h exp %h", i, InstrD, m_instr); end
         if (PC_4D !== m_pc4) begin n_fail++; $display("FAIL rnd_pc4[%0d] got %h exp %h", i, PC_4D, m_pc4); end
         if (ExcCodeD !== m_exc) begin n_fail++; $display("FAIL rnd_exc[%0d] got %0d exp %0d", i, ExcCodeD, m_exc); end
         if (if_bdD !== m_bd) begin n_fail++; $display("FAIL rnd_bd[%0d] got %b exp %b", i, if_bdD, m_bd); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jr_misaligned();
      test_stall_redirect();
      test_exc_eret();
      test_range();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
